// File: rtl/fpga_template_pkg.sv
// Shared types and helpers for the debug-message path.
package fpga_template_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } dbg_state_t;

    localparam logic [7:0] DBG_D = 8'h44;
    localparam logic [7:0] DBG_B = 8'h42;
    localparam logic [7:0] DBG_G = 8'h47;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            nib2ascii = 8'h30 + {4'h0, nib};
        end else begin
            nib2ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/dbg_rr_arbiter.sv
// Round-robin selector: picks the first request at or after the pointer, wrapping.
module dbg_rr_arbiter #(
    parameter int  NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_CH-1:0] grant_oh_o,
    output logic [CH_W-1:0]   grant_idx_o,
    output logic              grant_valid_o
);
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;

    // Search from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            int sum;
            int idx;
            sum = int'(ptr_q) + off;
            idx = (sum >= NUM_CH) ? sum - NUM_CH : sum;
            if (req_i[idx]) begin
                grant_valid_o   = 1'b1;
                grant_idx_o     = CH_W'(idx);
                grant_oh_o      = '0;
                grant_oh_o[idx] = 1'b1;
            end
        end
    end

    // Next pointer is one past the granted channel.
    always_comb begin
        if (!accept_i) begin
            ptr_d = ptr_q;
        end else if (int'(grant_idx_o) == NUM_CH - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_o + CH_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dbg_msg_sequencer.sv
// Turns trigger edges into "DBG<ch>: <hex>\r\n" byte streams, one channel at a time,
// with optional idle pacing after every accepted byte.
module dbg_msg_sequencer
    import fpga_template_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  DATA_W     = 16,
    parameter int  GAP_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [NUM_CH-1:0]        trig,
    input  logic [NUM_CH*DATA_W-1:0] snap_data,
    input  logic [NUM_CH-1:0]        enable_mask,
    input  logic                     clr_overrun,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [CH_W-1:0]          active_ch,
    output logic [NUM_CH-1:0]        overrun
);
    localparam int NIB   = DATA_W / 4;
    localparam int LEN   = 8 + NIB;
    localparam int IDX_W = $clog2(LEN);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(LEN - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    function automatic logic [7:0] msg_byte(input logic [CH_W-1:0] ch,
                                            input logic [DATA_W-1:0] snap,
                                            input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int n = 0; n < NIB; n++) begin
            if (int'(idx) == 6 + n) begin
                nib = snap[(NIB-1-n)*4 +: 4];
            end
        end
        if      (idx == IDX_W'(0)) msg_byte = DBG_D;
        else if (idx == IDX_W'(1)) msg_byte = DBG_B;
        else if (idx == IDX_W'(2)) msg_byte = DBG_G;
        else if (idx == IDX_W'(3)) msg_byte = nib2ascii(4'(ch));
        else if (idx == IDX_W'(4)) msg_byte = COLON;
        else if (idx == IDX_W'(5)) msg_byte = SPACE;
        else if (idx == CR_IDX)    msg_byte = CR;
        else if (idx == LAST_IDX)  msg_byte = LF;
        else                       msg_byte = nib2ascii(nib);
    endfunction

    logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q, edge_s;
    logic [NUM_CH-1:0] pend_q, pend_d, ovr_q, ovr_d, grant_clr_s;
    logic [NUM_CH-1:0] grant_oh_s;
    logic [CH_W-1:0]   grant_idx_s;
    logic              grant_valid_s, accept_s;
    dbg_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d, busy_q, busy_d;

    dbg_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk          (clk),
        .resetb       (resetb),
        .req_i        (pend_q),
        .accept_i     (accept_s),
        .grant_oh_o   (grant_oh_s),
        .grant_idx_o  (grant_idx_s),
        .grant_valid_o(grant_valid_s)
    );

    assign edge_s = sync2_q & ~prev_q;

    // Pending/overrun update; a new edge beats a same-cycle clear.
    always_comb begin
        grant_clr_s = accept_s ? grant_oh_s : '0;
        pend_d      = enable_mask & (edge_s | (pend_q & ~grant_clr_s));
        ovr_d       = (edge_s & pend_q & ~grant_clr_s) | (clr_overrun ? '0 : ovr_q);
    end

    // Message FSM next state; output bytes are precomputed so they leave a register.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        last_d   = last_q;
        snap_d   = snap_q;
        ch_d     = ch_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    accept_s = 1'b1;
                    state_d  = EMIT;
                    ch_d     = grant_idx_s;
                    snap_d   = snap_data[int'(grant_idx_s)*DATA_W +: DATA_W];
                    idx_d    = '0;
                    gap_d    = '0;
                    last_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (tx_ready) begin
                    last_d = (idx_q == LAST_IDX);
                    gap_d  = '0;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = idx_q;
                    end
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EMIT;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = last_q ? IDLE : EMIT;
                end else begin
                    state_d = GAP;
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tx_valid_d = (state_d == EMIT);
        tx_data_d  = tx_valid_d ? msg_byte(ch_d, snap_d, idx_d) : 8'h00;
        busy_d     = (state_d != IDLE);
    end

    // All state registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            ovr_q      <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            snap_q     <= '0;
            ch_q       <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= trig;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            snap_q     <= snap_d;
            ch_q       <= ch_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign active_ch = ch_q;
    assign overrun   = ovr_q;

endmodule
